// File: rtl/gps_pkg.sv
// gps_pkg: receiver state type, ASCII constants and a majority helper shared across the GPS serial path
package gps_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} gps_rx_state_t;
    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_STAR = 8'h2A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction
endpackage

// File: rtl/bit_sync.sv
// bit_sync: two-flop synchronizer for an asynchronous pin, both flops reset to RST_VAL
module bit_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        meta <= rst ? RST_VAL : d;
        q <= rst ? RST_VAL : meta;
    end
endmodule

// File: rtl/gps_uart_rx.sv
// gps_uart_rx: 8N1 GPS UART receiver with mid-bit sampling; GPS_RX_MAJORITY_EN selects 2-of-3 voting per sample point
module gps_uart_rx #(
    parameter int SYSCLK_FREQ = 100_000_000,
    parameter int BAUD = 9600
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       gpsRx,
    output logic [7:0] dataString,
    output logic       dataReady,
    output logic       frameErr,
    output logic       rxBusy
);
    import gps_pkg::*;
    localparam int CLKS_PER_BIT = SYSCLK_FREQ / BAUD;
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID = CW'(HALF_BIT - 1);
    if (CLKS_PER_BIT < 8) begin : g_bad_rate
        $error("gps_uart_rx: CLKS_PER_BIT must be at least 8");
    end
    logic rx_sync;
    logic rx_now;
    logic bit_val;
    gps_rx_state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shreg;
    bit_sync #(.RST_VAL(1'b1)) u_sync (
        .clk(sclk),
        .rst(rst),
        .d(gpsRx),
        .q(rx_sync)
    );
`ifdef GPS_RX_MAJORITY_EN
    // smp[0] is the newest synchronized sample; the vote spans counts target-2..target
    logic [2:0] smp;
    always_ff @(posedge sclk) smp <= rst ? 3'b111 : {smp[1:0], rx_sync};
    assign rx_now = smp[0];
    assign bit_val = maj3(smp);
`else
    logic smp;
    always_ff @(posedge sclk) smp <= rst | rx_sync;
    assign rx_now = smp;
    assign bit_val = smp;
`endif
    always_ff @(posedge sclk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shreg <= '0;
            dataString <= '0;
            dataReady <= 1'b0;
            frameErr <= 1'b0;
            rxBusy <= 1'b0;
        end else begin
            dataReady <= 1'b0;
            frameErr <= 1'b0;
            cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    rxBusy <= !rx_now;
                    if (!rx_now) state <= START;
                end
                START: if (cnt == MID) begin
                    cnt <= '0;
                    rxBusy <= !bit_val;
                    state <= bit_val ? IDLE : DATA;
                end
                DATA: if (cnt == BIT_END) begin
                    cnt <= '0;
                    shreg <= {bit_val, shreg[7:1]};
                    idx <= idx + 1'b1;
                    if (idx == 3'd7) state <= STOP;
                end
                STOP: if (cnt == BIT_END) begin
                    // rxBusy is held through the strobe cycle and drops from IDLE
                    cnt <= '0;
                    state <= bit_val ? IDLE : BREAK;
                    dataReady <= bit_val;
                    frameErr <= !bit_val;
                    if (bit_val) dataString <= shreg;
                end
                BREAK: if (rx_now) begin
                    cnt <= '0;
                    rxBusy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gps_uart_rx.sv
// tb_gps_uart_rx: frame-level scoreboard bench; each frame start predicts one strobe a fixed latency later
module tb_gps_uart_rx;
    localparam int CPB = 10;
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;
`ifdef GPS_RX_MAJORITY_EN
    localparam logic [7:0] SPIKE_EXP = 8'hFF;
`else
    localparam logic [7:0] SPIKE_EXP = 8'h00;
`endif
    typedef struct {
        bit lvl;
        bit mark;
        bit exp_ev;
        bit ferr;
        logic [7:0] data;
    } lvl_t;
    typedef struct {
        int at;
        bit ferr;
        logic [7:0] data;
    } ev_t;
    typedef struct {
        logic [7:0] d;
        bit stop_ok;
        int stop_len;
        bit spike;
        int gap;
        logic [7:0] exp_d;
    } vec_t;
    logic sclk = 1'b0;
    logic rst = 1'b1;
    logic gpsRx = 1'b1;
    logic [7:0] dataString;
    logic dataReady;
    logic frameErr;
    logic rxBusy;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    bit mon_on = 1'b0;
    logic [7:0] exp_str = 8'h00;
    lvl_t line_q[$];
    ev_t sb[$];
    vec_t tv[9];

    gps_uart_rx #(.SYSCLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .sclk(sclk),
        .rst(rst),
        .gpsRx(gpsRx),
        .dataString(dataString),
        .dataReady(dataReady),
        .frameErr(frameErr),
        .rxBusy(rxBusy)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic lvl_t lv(input bit l);
        lvl_t e;
        e = '{l, 1'b0, 1'b0, 1'b0, 8'h00};
        return e;
    endfunction

    // a level popped here is captured by the sync flop at the next edge (cycle 0 for a marked start)
    always @(negedge sclk) begin
        lvl_t e;
        ev_t v;
        if (line_q.size() > 0) begin
            e = line_q.pop_front();
            gpsRx = e.lvl;
            if (e.mark) t0 = cyc + 1;
            if (e.exp_ev) begin
                v = '{cyc + 1 + LAT, e.ferr, e.data};
                sb.push_back(v);
            end
        end else gpsRx = 1'b1;
    end

    always @(negedge sclk) begin
        ev_t ev;
        if (mon_on) begin
            if (dataReady || frameErr) begin
                if (sb.size() == 0) chk("unexpected strobe", {dataReady, frameErr}, 0);
                else begin
                    ev = sb.pop_front();
                    chk("strobe cycle", cyc, ev.at);
                    chk("strobe kind", {frameErr, dataReady}, ev.ferr ? 2 : 1);
                    if (!ev.ferr) exp_str = ev.data;
                end
            end
            if (sb.size() > 0 && cyc > sb[0].at) begin
                chk("missed strobe", cyc, sb[0].at);
                void'(sb.pop_front());
            end
            chk("dataString", dataString, exp_str);
        end
    end

    task automatic send(input logic [7:0] d, input bit stop_ok, input int stop_len, input bit spike,
                        input int gap, input bit exp_ev, input logic [7:0] exp_d);
        lvl_t s;
        s = '{1'b0, 1'b1, exp_ev, !stop_ok, exp_d};
        line_q.push_back(s);
        repeat (CPB - 1) line_q.push_back(lv(1'b0));
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < CPB; c++) line_q.push_back(lv((spike && c == 5) ? 1'b0 : d[b]));
        repeat (stop_len) line_q.push_back(lv(stop_ok));
        repeat (gap) line_q.push_back(lv(1'b1));
    endtask

    task automatic wait_cyc(input int c);
        int n = 0;
        while (cyc != c && n < 2000) begin
            @(negedge sclk);
            n++;
        end
        if (cyc != c) begin
            errors++;
            $display("FAIL wait_cyc: cycle %0d not reached, at %0d", c, cyc);
        end
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((line_q.size() > 0 || sb.size() > 0) && n < lim) begin
            @(negedge sclk);
            n++;
        end
        if (n >= lim) begin
            errors++;
            $display("FAIL drain: %0d levels and %0d strobes pending after %0d cycles", line_q.size(), sb.size(), lim);
        end
        repeat (5) @(negedge sclk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        bit ok;
        tv[0] = '{8'h47, 1'b1, 10, 1'b0, 0, 8'h47};
        tv[1] = '{8'h50, 1'b1, 10, 1'b0, 0, 8'h50};
        tv[2] = '{8'h47, 1'b1, 10, 1'b0, 0, 8'h47};
        tv[3] = '{8'h47, 1'b1, 10, 1'b0, 0, 8'h47};
        tv[4] = '{8'h41, 1'b1, 10, 1'b0, 20, 8'h41};
        tv[5] = '{8'h55, 1'b0, 50, 1'b0, 20, 8'h00};
        tv[6] = '{8'h0D, 1'b1, 10, 1'b0, 20, 8'h0D};
        tv[7] = '{8'hFF, 1'b1, 10, 1'b1, 20, SPIKE_EXP};
        tv[8] = '{8'h2A, 1'b1, 10, 1'b0, 5, 8'h2A};
        repeat (3) @(posedge sclk);
        #1;
        chk("reset dataString", dataString, 0);
        chk("reset dataReady", dataReady, 0);
        chk("reset frameErr", frameErr, 0);
        chk("reset rxBusy", rxBusy, 0);
        rst = 1'b0;
        mon_on = 1'b1;

        @(posedge sclk);
        send(8'h24, 1'b1, 10, 1'b0, 10, 1'b1, 8'h24);
        @(negedge sclk);
        #1;
        wait_cyc(t0 + 2);
        chk("busy before cycle 3", rxBusy, 0);
        wait_cyc(t0 + 3);
        chk("busy at cycle 3", rxBusy, 1);
        wait_cyc(t0 + LAT);
        chk("ready at cycle 98", dataReady, 1);
        chk("busy during strobe", rxBusy, 1);
        wait_cyc(t0 + LAT + 1);
        chk("busy after strobe", rxBusy, 0);
        drain(500);

        @(posedge sclk);
        line_q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        line_q.push_back(lv(1'b0));
        line_q.push_back(lv(1'b0));
        @(negedge sclk);
        #1;
        wait_cyc(t0 + 5);
        chk("glitch busy", rxBusy, 1);
        wait_cyc(t0 + 9);
        chk("glitch busy cleared", rxBusy, 0);
        @(posedge sclk);
        send(8'h2C, 1'b1, 10, 1'b0, 10, 1'b1, 8'h2C);
        drain(500);

        @(posedge sclk);
        send(8'hA5, 1'b1, 10, 1'b0, 0, 1'b0, 8'h00);
        @(negedge sclk);
        #1;
        wait_cyc(t0 + 39);
        rst = 1'b1;
        @(posedge sclk);
        #1;
        exp_str = 8'h00;
        line_q.delete();
        chk("abort dataString", dataString, 0);
        chk("abort dataReady", dataReady, 0);
        chk("abort frameErr", frameErr, 0);
        chk("abort rxBusy", rxBusy, 0);
        rst = 1'b0;
        repeat (20) @(posedge sclk);
        send(8'h0A, 1'b1, 10, 1'b0, 10, 1'b1, 8'h0A);
        drain(500);

        @(posedge sclk);
        foreach (tv[i]) send(tv[i].d, tv[i].stop_ok, tv[i].stop_len, tv[i].spike, tv[i].gap, 1'b1, tv[i].exp_d);
        drain(2000);

        @(posedge sclk);
        for (int i = 0; i < 30; i++) begin
            rd = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 9) != 0);
            send(rd, ok, 10, 1'b0, ok ? $urandom_range(0, 3) : $urandom_range(2, 5), 1'b1, rd);
        end
        drain(5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gps_uart_rx.md
# gps_uart_rx

8N1 UART receiver for the GPS serial line, directly upstream of the NMEA sentence parser. Synchronises the asynchronous GPS TX pin into the `sclk` domain, detects and validates start bits, and samples each bit at mid-bit. Presents each good byte on `dataString` with a one-cycle `dataReady` strobe, in exactly the form the parser consumes. Flags framing errors separately, so the parser resets only on real sentence errors.

## Interface
Parameters:
- `SYSCLK_FREQ`, 100_000_000: `sclk` frequency in Hz.
- `BAUD`, 9600: GPS line rate.
- Derived localparam `CLKS_PER_BIT` = SYSCLK_FREQ/BAUD (integer divide).
- Derived localparam `HALF_BIT` = CLKS_PER_BIT/2.
- Elaboration error if `CLKS_PER_BIT` < 8.

Ports:
- `sclk`  in  1  system clock; one clock domain only.
- `rst`  in  1  synchronous, active-high reset.
- `gpsRx`  in  1  asynchronous serial input; idles high.
- `dataString`  out  8  last good received byte; LSB received first.
- `dataReady`  out  1  one-cycle strobe; `dataString` is valid in the same cycle.
- `frameErr`  out  1  one-cycle strobe when the stop bit is sampled low.
- `rxBusy`  out  1  high while the FSM is outside IDLE.

## Operation
- `gpsRx` passes through a 2-flop synchronizer. Both flops reset to 1.
- FSM states: IDLE, START, DATA, STOP, BREAK. A single bit counter is cleared on every state entry and on every bit boundary.
- IDLE: a synchronized low moves the FSM to START.
- START: at count `HALF_BIT`-1, sample the line.
  - Low: go to DATA.
  - High: false start; return to IDLE with no strobe.
- DATA: sample every `CLKS_PER_BIT` cycles, 8 times. Shift each bit into bit 7 of the shift register (shift right). Then go to STOP.
- STOP: sample after `CLKS_PER_BIT` cycles.
  - High: load `dataString` from the shift register, pulse `dataReady`, go to IDLE.
  - Low: pulse `frameErr`, leave `dataString` unchanged, go to BREAK.
- BREAK: wait for a synchronized high, then go to IDLE. Held-low lines produce exactly one `frameErr`.
- `dataReady` and `frameErr` are never high in the same cycle.

## Timing
- Reset values:
  - `dataString`=8'h00, `dataReady`=0, `frameErr`=0, `rxBusy`=0.
  - FSM=IDLE, counter=0, shift register=0.
- Cycle 0 is the `sclk` edge where sync flop 1 first captures low.
- `dataReady` is high at cycle 3 + `HALF_BIT` + 9·`CLKS_PER_BIT`.
- `rxBusy` rises at cycle 3 and falls in the cycle after the `dataReady` or `frameErr` strobe (BREAK excepted: it stays high until the line goes high).
- A start edge arriving in IDLE one cycle after a strobe is accepted. Back-to-back bytes with a single stop bit are received without loss.
- `rst` asserted mid-byte: abort immediately, emit no strobe, return to reset values on the next edge.
- `dataString` is stable except on the `dataReady` cycle.

## Configuration
- `GPS_RX_MAJORITY_EN` defined:
  - Each sample point (start, data, stop) takes the 2-of-3 majority of synchronized samples at counts target-2, target-1 and target.
  - The decision is made at target, so latency is unchanged.
- Undefined: single sample at target.
- Port list is identical in both builds.

## Structure
- Shared `gps_pkg` holds:
  - `gps_rx_state_t` enum (IDLE, START, DATA, STOP, BREAK);
  - ASCII constants used across the GPS path (`$`, `,`, `*`, CR, LF).
- Sub-module `bit_sync`: a 2-flop synchronizer, parameterised by reset value, reusable for other async pins.
- The FSM, counter and shift register stay in `gps_uart_rx`.

## Test plan
All scenarios use `SYSCLK_FREQ`=1_000_000, `BAUD`=100_000 (`CLKS_PER_BIT`=10, `HALF_BIT`=5).
- Send byte 8'h24 (`$`) with a good stop bit.
  - Expect one `dataReady` at cycle 98 relative to cycle 0.
  - `dataString`=8'h24; no `frameErr`.
- Send "GPGGA" back-to-back with one stop bit each.
  - Expect 5 strobes with 8'h47, 8'h50, 8'h47, 8'h47, 8'h41 in order.
  - Strobes exactly 100 cycles apart.
- Send a 3-cycle low glitch on an idle line.
  - Expect no strobe and `rxBusy` low again by cycle 9.
  - Next valid byte 8'h2C is received correctly.
- Send 8'h55 with the stop bit low, holding the line low for 50 cycles.
  - Expect exactly one `frameErr`, no `dataReady`, `dataString` unchanged.
  - Next byte 8'h0D is received once the line idles.
- Assert `rst` for 1 cycle at cycle 40 of byte 8'hA5.
  - Expect no strobe and all outputs at reset values.
  - Following byte 8'h0A is received correctly.
- With `GPS_RX_MAJORITY_EN`, send 8'hFF with a 1-cycle low spike at each data-bit target.
  - Expect `dataString`=8'hFF.
  - Without the macro: expect a corrupted byte.
